mac_tx_ctrl: RTL



---
 rtl/mac_tx_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_ctrl.sv
// mac_tx_ctrl: TX frame sequencer between the application and the PCS.
// Emits the static MAC header, forwards payload beats, zero-pads short
// payloads to the minimum length and enforces a fixed inter-packet gap.
// Optional build macro: MAC_TX_CTRL_STATS_EN adds frame and pad-frame
// counters (frames_o, pad_frames_o).
module mac_tx_ctrl #(
    parameter int DATA_W        = 64,
    parameter int KEEP_W        = DATA_W / 8,
    parameter int HEAD_N        = 26,
    parameter int HEAD_W        = HEAD_N * 8,
    parameter int MIN_PAYLOAD_N = 42,
    parameter int IPG_CYC       = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [HEAD_W-1:0] head_i,
    input  logic              app_valid_i,
    output logic              app_ready_o,
    input  logic [DATA_W-1:0] app_data_i,
    input  logic [KEEP_W-1:0] app_keep_i,
    input  logic              app_last_i,
    input  logic              pcs_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              start_o,
    output logic              last_o,
    output logic              busy_o
`ifdef MAC_TX_CTRL_STATS_EN
    ,
    output logic [31:0]       frames_o,
    output logic [31:0]       pad_frames_o
`endif
);

    // Byte mask with the lowest n enables set.
    function automatic logic [KEEP_W-1:0] lowMask(input int n);
        logic [KEEP_W-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam int HEAD_WORDS      = (HEAD_N + KEEP_W - 1) / KEEP_W;
    localparam int HEAD_EXT_W      = HEAD_WORDS * DATA_W;
    localparam int HEAD_LAST_BYTES = HEAD_N - (HEAD_WORDS - 1) * KEEP_W;
    localparam int HIDX_W          = (HEAD_WORDS > 1) ? $clog2(HEAD_WORDS) : 1;
    localparam int CNT_W           = $clog2(MIN_PAYLOAD_N + KEEP_W + 1);
    localparam int IPG_W           = $clog2(IPG_CYC + 2);

    localparam logic [KEEP_W-1:0] HEAD_LAST_KEEP = lowMask(HEAD_LAST_BYTES);
    localparam logic [KEEP_W-1:0] HEAD0_KEEP     =
        (HEAD_WORDS == 1) ? HEAD_LAST_KEEP : {KEEP_W{1'b1}};
    localparam logic [HIDX_W-1:0] LAST_HIDX      = HIDX_W'(HEAD_WORDS - 1);
    localparam logic [CNT_W-1:0]  MIN_C          = CNT_W'(MIN_PAYLOAD_N);
    localparam logic [CNT_W-1:0]  KEEP_C         = CNT_W'(KEEP_W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAD = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_IPG  = 3'd4;

    logic [2:0]        r_state;
    logic [HEAD_W-1:0] r_head;
    logic [HIDX_W-1:0] r_hidx;
    logic [CNT_W-1:0]  r_cnt;
    logic [IPG_W-1:0]  r_ipg_cnt;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_start;
    logic              r_last;

    logic                  w_xfer;
    logic                  w_adv;
    logic                  w_app_ready;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_keep_pop;
    logic [CNT_W-1:0]      w_cnt_sum;
    logic [CNT_W-1:0]      w_cnt_sat;
    logic [CNT_W-1:0]      w_remain;
    logic [CNT_W-1:0]      w_pad_n;
    logic [KEEP_W-1:0]     w_pad_keep;
    logic                  w_pad_done;
    logic [HEAD_EXT_W-1:0] w_head_ext;
    logic [HEAD_EXT_W-1:0] w_head_in_ext;
    logic [DATA_W-1:0]     w_head_word;
    logic [KEEP_W-1:0]     w_head_keep;
    logic                  w_ipg_done;

    // The output register may load a new word whenever it is empty or the
    // PCS is taking the current one; payload is only accepted in DATA.
    assign w_xfer      = r_valid & pcs_ready_i;
    assign w_adv       = ~r_valid | pcs_ready_i;
    assign w_app_ready = (r_state == S_DATA) & pcs_ready_i;
    assign w_accept    = w_app_ready & app_valid_i;

    // Count enabled bytes on the incoming payload beat.
    always_comb begin
        w_keep_pop = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_keep_pop = w_keep_pop + CNT_W'(app_keep_i[i]);
        end
    end

    // Byte count update with saturation, and sizing of the next pad word.
    always_comb begin
        w_cnt_sum  = r_cnt + w_keep_pop;
        w_cnt_sat  = (w_cnt_sum >= MIN_C) ? MIN_C : w_cnt_sum;
        w_remain   = MIN_C - r_cnt;
        w_pad_n    = (w_remain > KEEP_C) ? KEEP_C : w_remain;
        w_pad_keep = lowMask(int'(w_pad_n));
        w_pad_done = ((r_cnt + w_pad_n) >= MIN_C);
    end

    // Zero-extend the header to a whole number of words and pick the next one.
    always_comb begin
        w_head_ext                   = '0;
        w_head_ext[HEAD_W-1:0]       = r_head;
        w_head_in_ext                = '0;
        w_head_in_ext[HEAD_W-1:0]    = head_i;
        w_head_word = w_head_ext[int'(r_hidx) * DATA_W +: DATA_W];
        w_head_keep = (r_hidx == LAST_HIDX) ? HEAD_LAST_KEEP : {KEEP_W{1'b1}};
    end

    assign w_ipg_done = ((int'(r_ipg_cnt) + 1) >= IPG_CYC);

    // Frame sequencer: state, header capture, byte/gap counters and the
    // registered output word all advance together.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_head    <= '0;
            r_hidx    <= '0;
            r_cnt     <= '0;
            r_ipg_cnt <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_keep    <= '0;
            r_start   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_start <= 1'b0;
                    r_last  <= 1'b0;
                    if (app_valid_i) begin
                        r_head  <= head_i;
                        r_hidx  <= HIDX_W'(1);
                        r_cnt   <= '0;
                        r_data  <= w_head_in_ext[DATA_W-1:0];
                        r_keep  <= HEAD0_KEEP;
                        r_valid <= 1'b1;
                        r_start <= 1'b1;
                        r_state <= (HEAD_WORDS == 1) ? S_DATA : S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (w_adv) begin
                        r_data  <= w_head_word;
                        r_keep  <= w_head_keep;
                        r_valid <= 1'b1;
                        r_start <= 1'b0;
                        r_last  <= 1'b0;
                        r_hidx  <= r_hidx + HIDX_W'(1);
                        if (r_hidx == LAST_HIDX) begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_data  <= app_data_i;
                        r_keep  <= app_keep_i;
                        r_valid <= 1'b1;
                        r_start <= 1'b0;
                        r_cnt   <= w_cnt_sat;
                        r_last  <= 1'b0;
                        if (app_last_i) begin
                            if (w_cnt_sum >= MIN_C) begin
                                r_last    <= 1'b1;
                                r_ipg_cnt <= '0;
                                r_state   <= S_IPG;
                            end else begin
                                r_state   <= S_PAD;
                            end
                        end
                    end else if (w_adv) begin
                        r_valid <= 1'b0;
                        r_start <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                S_PAD: begin
                    if (w_adv) begin
                        r_data  <= '0;
                        r_keep  <= w_pad_keep;
                        r_valid <= 1'b1;
                        r_start <= 1'b0;
                        r_last  <= w_pad_done;
                        r_cnt   <= r_cnt + w_pad_n;
                        if (w_pad_done) begin
                            r_ipg_cnt <= '0;
                            r_state   <= S_IPG;
                        end
                    end
                end
                S_IPG: begin
                    if (r_valid) begin
                        if (pcs_ready_i) begin
                            r_valid <= 1'b0;
                            r_start <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end else if (w_ipg_done) begin
                        r_ipg_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_ipg_cnt <= r_ipg_cnt + IPG_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_start <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign app_ready_o = w_app_ready;
    assign valid_o     = r_valid;
    assign data_o      = r_data;
    assign keep_o      = r_keep;
    assign start_o     = r_start;
    assign last_o      = r_last;
    assign busy_o      = (r_state != S_IDLE);

`ifdef MAC_TX_CTRL_STATS_EN
    logic [31:0] r_frames;
    logic [31:0] r_pad_frames;
    logic        w_last_xfer;
    logic        w_enter_pad;

    assign w_last_xfer = w_xfer & r_last;
    assign w_enter_pad = (r_state == S_DATA) & w_accept & app_last_i & (w_cnt_sum < MIN_C);

    // Free-running frame statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_frames     <= '0;
            r_pad_frames <= '0;
        end else begin
            if (w_last_xfer) r_frames <= r_frames + 32'd1;
            if (w_enter_pad) r_pad_frames <= r_pad_frames + 32'd1;
        end
    end

    assign frames_o     = r_frames;
    assign pad_frames_o = r_pad_frames;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
